key_entry_loader: RTL and testbench

//   Upstream stage of the keyed LED-blink core. Converts three raw push buttons
//   (enter-0, enter-1, commit) into an 8-bit key, one bit per button press.

---
 rtl/key_entry_loader.sv | 135 +++++++++++++
 tb/tb_key_entry_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/key_entry_loader.sv
// Button-driven key entry: synchronises and debounces three push buttons and
// assembles an MSB-first key. Optional idle timeout enabled by KEY_TIMEOUT_EN.
module key_entry_loader #(
   parameter int          KEY_WIDTH       = 8,
   parameter int          DEBOUNCE_CYCLES = 1_000_000,
   parameter logic [27:0] TIMEOUT_CYCLES  = 28'h7FFFFFF
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           btn0,
   input  logic                           btn1,
   input  logic                           btn_commit,
   output logic [KEY_WIDTH-1:0]           key,
   output logic                           key_valid,
   output logic [$clog2(KEY_WIDTH+1)-1:0] bit_count,
   output logic                           entry_err
);

   localparam int CW = $clog2(KEY_WIDTH + 1);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

   logic [2:0]    raw, sync1, sync2, level, level_d, press;
   logic [DW-1:0] db_cnt [3];

   state_t               state, state_next;
   logic [KEY_WIDTH-1:0] shift, shift_next, key_next;
   logic [CW-1:0]        count, count_next;
   logic                 key_valid_next, err_next;
   logic                 commit, bit_press, bit_val, timeout;

   assign raw = {btn_commit, btn1, btn0};

   // Level flips only after the synced input disagrees for DEBOUNCE_CYCLES straight cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= '0;
         sync2   <= '0;
         level   <= '0;
         level_d <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         level_d <= level;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i] <= '0;
               level[i]  <= sync2[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign press     = level & ~level_d;
   assign commit    = press[2];
   assign bit_press = (press[0] ^ press[1]) & ~commit;
   assign bit_val   = press[1];

`ifdef KEY_TIMEOUT_EN
   logic [27:0] idle_cnt, idle_next;

   assign timeout = (state != IDLE) && (idle_cnt == TIMEOUT_CYCLES - 28'd1);

   always_comb begin
      idle_next = idle_cnt + 28'd1;
      if (state_next == IDLE || commit || (bit_press && state != FULL))
         idle_next = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) idle_cnt <= '0;
      else        idle_cnt <= idle_next;
   end
`else
   assign timeout = 1'b0;
`endif

   // Timeout beats commit, and commit beats any bit press arriving in the same cycle
   always_comb begin
      state_next     = state;
      shift_next     = shift;
      count_next     = count;
      key_next       = key;
      key_valid_next = key_valid;
      err_next       = 1'b0;
      if (timeout) begin
         shift_next = '0;
         count_next = '0;
         err_next   = 1'b1;
         state_next = IDLE;
      end else if (commit) begin
         if (state == FULL) begin
            key_next       = shift;
            key_valid_next = 1'b1;
         end else begin
            err_next = 1'b1;
         end
         shift_next = '0;
         count_next = '0;
         state_next = IDLE;
      end else if (bit_press && state != FULL) begin
         shift_next = {shift[KEY_WIDTH-2:0], bit_val};
         count_next = count + 1'b1;
         state_next = (count_next == CW'(KEY_WIDTH)) ? FULL : COLLECT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shift     <= '0;
         count     <= '0;
         key       <= '0;
         key_valid <= 1'b0;
         entry_err <= 1'b0;
      end else begin
         state     <= state_next;
         shift     <= shift_next;
         count     <= count_next;
         key       <= key_next;
         key_valid <= key_valid_next;
         entry_err <= err_next;
      end
   end

   assign bit_count = count;

endmodule

// File: tb/tb_key_entry_loader.sv
// Scoreboard bench for key_entry_loader: expected commit/error events are queued
// as buttons are driven and matched when the DUT reports them.
module tb_key_entry_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn0, btn1, btn_commit;
   logic [7:0] key;
   logic       key_valid;
   logic [3:0] bit_count;
   logic       entry_err;

   key_entry_loader #(
      .KEY_WIDTH      (8),
      .DEBOUNCE_CYCLES(4),
      .TIMEOUT_CYCLES (28'd64)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn0      (btn0),
      .btn1      (btn1),
      .btn_commit(btn_commit),
      .key       (key),
      .key_valid (key_valid),
      .bit_count (bit_count),
      .entry_err (entry_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_commit;
      logic [7:0] key;
   } event_t;

   event_t     sb_q[$];
   int         n_compared   = 0;
   int         n_mismatched = 0;
   int         prev_count   = 0;
   logic [7:0] m_shift      = '0;
   logic [7:0] m_key        = '0;
   logic       m_valid      = 1'b0;
   int         m_count      = 0;

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference model of one button gesture; queues the event the DUT must report
   task automatic model_press(input logic [2:0] mask);
      event_t e;
      if (mask[2]) begin
         e.is_commit = (m_count == 8);
         e.key       = m_shift;
         sb_q.push_back(e);
         if (m_count == 8) begin
            m_key   = m_shift;
            m_valid = 1'b1;
         end
         m_shift = '0;
         m_count = 0;
      end else if ((mask[0] ^ mask[1]) && m_count < 8) begin
         m_shift = {m_shift[6:0], mask[1]};
         m_count++;
      end
   endtask

   task automatic press_combo(input logic [2:0] mask);
      model_press(mask);
      @(negedge clk);
      {btn_commit, btn1, btn0} = mask;
      repeat (10) @(negedge clk);
      {btn_commit, btn1, btn0} = 3'b000;
      repeat (10) @(negedge clk);
      check_output("bit_count", 32'(bit_count), 32'(m_count));
      check_output("key", 32'(key), 32'(m_key));
      check_output("key_valid", 32'(key_valid), 32'(m_valid));
   endtask

   task automatic enter_bits(input logic [7:0] val, input int n);
      for (int i = n - 1; i >= 0; i--) press_combo(val[i] ? 3'b010 : 3'b001);
   endtask

   // Commits show as bit_count dropping from 8 to 0 without an error pulse
   always @(negedge clk) begin
      event_t e;
      if (!rst_n) begin
         prev_count = 0;
      end else begin
         if (entry_err || (prev_count == 8 && bit_count == 0)) begin
            if (sb_q.size() == 0) begin
               check_output("sb_unexpected_event", 32'(sb_q.size()), 32'd1);
            end else begin
               e = sb_q.pop_front();
               check_output("event_kind", 32'(!entry_err), 32'(e.is_commit));
               if (!entry_err) check_output("key_commit", 32'(key), 32'(e.key));
            end
         end
         prev_count = int'(bit_count);
      end
   end

   initial begin
      rst_n = 1'b0;
      {btn_commit, btn1, btn0} = 3'b000;
      repeat (3) @(negedge clk);
      check_output("rst_key", 32'(key), 32'd0);
      check_output("rst_valid", 32'(key_valid), 32'd0);
      check_output("rst_count", 32'(bit_count), 32'd0);
      check_output("rst_err", 32'(entry_err), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] basic entry 8'hB2");
      enter_bits(8'hB2, 8);
      press_combo(3'b100);
      check_output("key_b2", 32'(key), 32'hB2);

      $display("[TB] glitch rejection");
      btn1 = 1'b1;
      repeat (3) @(negedge clk);
      btn1 = 1'b0;
      repeat (10) @(negedge clk);
      check_output("glitch_count", 32'(bit_count), 32'd0);
      model_press(3'b010);
      btn1 = 1'b1;
      repeat (8) @(negedge clk);
      btn1 = 1'b0;
      repeat (10) @(negedge clk);
      check_output("hold_count", 32'(bit_count), 32'd1);

      $display("[TB] short commit");
      enter_bits(8'h02, 2);
      check_output("three_bits", 32'(bit_count), 32'd3);
      press_combo(3'b100);
      check_output("key_kept", 32'(key), 32'hB2);

      $display("[TB] presses beyond full ignored");
      enter_bits(8'h6C, 8);
      press_combo(3'b001);
      press_combo(3'b001);
      check_output("full_count", 32'(bit_count), 32'd8);
      press_combo(3'b100);
      check_output("key_6c", 32'(key), 32'h6C);

      $display("[TB] simultaneous presses");
      press_combo(3'b010);
      press_combo(3'b011);
      check_output("dual_ignored", 32'(bit_count), 32'd1);
      enter_bits(8'h4B, 7);
      press_combo(3'b110);
      check_output("key_commit_win", 32'(key), 32'hCB);

`ifdef KEY_TIMEOUT_EN
      $display("[TB] idle timeout");
      enter_bits(8'h15, 5);
      sb_q.push_back('{is_commit: 1'b0, key: 8'h00});
      m_shift = '0;
      m_count = 0;
      repeat (80) @(negedge clk);
      check_output("timeout_count", 32'(bit_count), 32'd0);
      check_output("timeout_key", 32'(key), 32'hCB);
`endif

      $display("[TB] asynchronous reset mid-entry");
      enter_bits(8'h03, 2);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_output("async_key", 32'(key), 32'd0);
      check_output("async_valid", 32'(key_valid), 32'd0);
      check_output("async_count", 32'(bit_count), 32'd0);
      check_output("async_err", 32'(entry_err), 32'd0);
      m_shift = '0;
      m_key   = '0;
      m_valid = 1'b0;
      m_count = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      enter_bits(8'h5A, 8);
      press_combo(3'b100);
      check_output("key_5a", 32'(key), 32'h5A);

      repeat (5) @(negedge clk);
      check_output("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
